// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one signed booth_mult between NREQ requesters.
// Latches the granted operands, fires a one-cycle start pulse and returns the product
// (or a timeout error) to the granted requester as a one-hot one-cycle response.
module mult_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned W          = 12,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned READY_MASK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_prod,
  output logic              rsp_err,
  output logic              busy,
  output logic [W-1:0]      mult_x,
  output logic [W-1:0]      mult_y,
  output logic              mult_start,
  input  logic [2*W-1:0]    mult_prod,
  input  logic              mult_ready
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   grant_q, grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      x_q, x_d;
  logic [W-1:0]      y_q, y_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0]    rsp_prod_q, rsp_prod_d;
  logic              rsp_err_q, rsp_err_d;

  logic              arb_found;
  logic [PtrW-1:0]   arb_idx;
  logic [31:0]       cand;
  logic [NREQ-1:0]   grant_oh;
  logic [PtrW-1:0]   rr_next;
  logic [CntW-1:0]   elapsed;

  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
  assign rr_next  = (grant_q == PtrW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  // Cycles since the start pulse; the first BUSY cycle is 1.
  assign elapsed  = cnt_q + CntW'(1);

  // Round-robin pick: first pending requester at or above rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NREQ;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PtrW-1:0];
      end
    end
  end

  // Next-state logic for the grant / issue / wait sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    rsp_valid_d = '0;
    rsp_prod_d  = rsp_prod_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        // No grant in the response cycle, so the next start is two cycles after it.
        if (arb_found && (rsp_valid_q == '0)) begin
          grant_d = arb_idx;
          x_d     = req_a[arb_idx*W +: W];
          y_d     = req_b[arb_idx*W +: W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        cnt_d = elapsed;
        // Ready is masked for the first READY_MASK cycles to skip a stale level.
        if (mult_ready && (elapsed > CntW'(READY_MASK))) begin
          rsp_prod_d  = mult_prod;
          rsp_err_d   = 1'b0;
          rsp_valid_d = grant_oh;
          rr_ptr_d    = rr_next;
          state_d     = StIdle;
        end else if (elapsed >= CntW'(TIMEOUT - 1)) begin
          rsp_prod_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = grant_oh;
          rr_ptr_d    = rr_next;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rsp_valid_q <= '0;
      rsp_prod_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Outputs decoded from registered state; ISSUE lasts exactly one cycle.
  always_comb begin
    mult_start = (state_q == StIssue);
    req_ack    = (state_q == StIssue) ? grant_oh : '0;
    busy       = (state_q != StIdle);
    mult_x     = x_q;
    mult_y     = y_q;
    rsp_valid  = rsp_valid_q;
    rsp_prod   = rsp_prod_q;
    rsp_err    = rsp_err_q;
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: acts as requesters and as the booth_mult model.
module tb_mult_arbiter;

  localparam int unsigned NREQ       = 2;
  localparam int unsigned W          = 12;
  localparam int unsigned TIMEOUT    = 64;
  localparam int unsigned READY_MASK = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [23:0]     req_a = '0;
  logic [23:0]     req_b = '0;
  logic [1:0]      req_ack;
  logic [1:0]      rsp_valid;
  logic [23:0]     rsp_prod;
  logic            rsp_err;
  logic            busy;
  logic [11:0]     mult_x;
  logic [11:0]     mult_y;
  logic            mult_start;
  logic [23:0]     mult_prod = '0;
  logic            mult_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mult_arbiter #(
    .NREQ      (NREQ),
    .W         (W),
    .TIMEOUT   (TIMEOUT),
    .READY_MASK(READY_MASK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mult_x    (mult_x),
    .mult_y    (mult_y),
    .mult_start(mult_start),
    .mult_prod (mult_prod),
    .mult_ready(mult_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    mult_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits for a start pulse, plays the multiplier and captures the response.
  task automatic run_mult(input int delay, input bit tied, input bit drop_on_ack,
                          output bit started, output int start_cyc, output logic [1:0] ack,
                          output logic [11:0] x, output logic [11:0] y, output int rsp_k,
                          output int rsp_cyc, output logic [1:0] rv, output logic [23:0] prod,
                          output logic err, output logic busy_nx);
    logic signed [23:0] p;
    started = 1'b0; start_cyc = -1; ack = '0; x = '0; y = '0;
    rsp_k = -1; rsp_cyc = -1; rv = '0; prod = '0; err = 1'b0; busy_nx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mult_start) begin
        started = 1'b1;
        break;
      end
    end
    if (!started) return;
    start_cyc = cyc;
    ack = req_ack;
    x = mult_x;
    y = mult_y;
    p = $signed(x) * $signed(y);
    mult_prod = p;
    if (drop_on_ack) req_valid = req_valid & ~req_ack;
    for (int k = 1; k <= int'(TIMEOUT) + 8; k++) begin
      @(posedge clk); #1;
      if (|rsp_valid) begin
        rsp_k = k; rsp_cyc = cyc; rv = rsp_valid; prod = rsp_prod; err = rsp_err;
        break;
      end
      mult_ready = tied || (k == delay);
    end
    mult_ready = 1'b0;
    @(posedge clk); #1;
    busy_nx = busy;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({req_ack, rsp_valid, rsp_prod, rsp_err, busy, mult_x, mult_y, mult_start} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b rv=%b prod=%h err=%b busy=%b x=%h y=%h st=%b, want all 0",
               req_ack, rsp_valid, rsp_prod, rsp_err, busy, mult_x, mult_y, mult_start);
    end
  endtask

  task automatic test_single();
    bit st; int sc, rk, rc; logic [1:0] ack, rv; logic [11:0] x, y; logic [23:0] pr;
    logic er, bn;
    int t0;
    req_a[11:0] = 12'd25; req_b[11:0] = 12'hFFD;
    req_valid = 2'b01;
    t0 = cyc;
    run_mult(13, 1'b0, 1'b1, st, sc, ack, x, y, rk, rc, rv, pr, er, bn);
    checks++;
    if (!st || sc != t0 + 1) begin
      failures++; $display("FAIL single_start: started=%0d at +%0d, want +1", st, sc - t0);
    end
    checks++;
    if (ack !== 2'b01 || x !== 12'd25 || y !== 12'hFFD) begin
      failures++; $display("FAIL single_issue: ack=%b x=%h y=%h, want 01 019 ffd", ack, x, y);
    end
    checks++;
    if (rk != 14 || rv !== 2'b01 || pr !== 24'hFFFFB5 || er !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: k=%0d rv=%b prod=%h err=%b, want 14 01 ffffb5 0", rk, rv, pr, er);
    end
    checks++;
    if (bn !== 1'b0 || rsp_valid !== 2'b00 || rsp_prod !== 24'hFFFFB5) begin
      failures++;
      $display("FAIL single_hold: busy=%b rv=%b prod=%h, want 0 00 ffffb5", bn, rsp_valid, rsp_prod);
    end
  endtask

  task automatic test_round_robin();
    bit st; int sc, rk, rc, prev_rc; logic [1:0] ack, rv; logic [11:0] x, y; logic [23:0] pr;
    logic er, bn;
    logic [1:0] exp_ack;
    logic [23:0] exp_pr;
    do_reset();
    req_a = {12'd4, 12'd2}; req_b = {12'd5, 12'd3};
    req_valid = 2'b11;
    prev_rc = -1;
    for (int i = 0; i < 4; i++) begin
      exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_pr  = (i % 2 == 0) ? 24'd6 : 24'd20;
      run_mult(5, 1'b0, 1'b0, st, sc, ack, x, y, rk, rc, rv, pr, er, bn);
      checks++;
      if (!st || ack !== exp_ack || rv !== exp_ack || pr !== exp_pr || er !== 1'b0) begin
        failures++;
        $display("FAIL rr_op%0d: ack=%b rv=%b prod=%h err=%b, want %b %b %h 0",
                 i, ack, rv, pr, er, exp_ack, exp_ack, exp_pr);
      end
      if (i > 0) begin
        checks++;
        if (sc - prev_rc != 2) begin
          failures++; $display("FAIL rr_gap%0d: start %0d cycles after rsp, want 2", i, sc - prev_rc);
        end
      end
      prev_rc = rc;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    bit st; int sc, rk, rc; logic [1:0] ack, rv; logic [11:0] x, y; logic [23:0] pr;
    logic er, bn;
    req_a[11:0] = 12'd7; req_b[11:0] = 12'd7;
    req_valid = 2'b01;
    run_mult(-1, 1'b0, 1'b1, st, sc, ack, x, y, rk, rc, rv, pr, er, bn);
    checks++;
    if (!st || rk != int'(TIMEOUT) || rv !== 2'b01 || er !== 1'b1 || pr !== 24'd0) begin
      failures++;
      $display("FAIL timeout_rsp: k=%0d rv=%b err=%b prod=%h, want %0d 01 1 000000",
               rk, rv, er, pr, TIMEOUT);
    end
    checks++;
    if (bn !== 1'b0) begin
      failures++; $display("FAIL timeout_busy: busy=%b, want 0", bn);
    end
  endtask

  task automatic test_ready_mask();
    bit st; int sc, rk, rc; logic [1:0] ack, rv; logic [11:0] x, y; logic [23:0] pr;
    logic er, bn;
    req_a = {12'hFFE, 12'd1}; req_b = {12'd9, 12'd1};
    mult_ready = 1'b1;
    req_valid = 2'b11;
    run_mult(-1, 1'b1, 1'b1, st, sc, ack, x, y, rk, rc, rv, pr, er, bn);
    req_valid = 2'b00;
    checks++;
    if (!st || ack !== 2'b10) begin
      failures++; $display("FAIL mask_grant: ack=%b, want 10 after rr moved past 0", ack);
    end
    checks++;
    if (rk != int'(READY_MASK) + 2 || rv !== 2'b10 || pr !== 24'hFFFFEE || er !== 1'b0) begin
      failures++;
      $display("FAIL mask_rsp: k=%0d rv=%b prod=%h err=%b, want %0d 10 ffffee 0",
               rk, rv, pr, er, READY_MASK + 2);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL mask_withdraw: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_busy();
    bit st, st2; int sc, rk, rc; logic [1:0] ack, rv; logic [11:0] x, y; logic [23:0] pr;
    logic er, bn;
    int bad;
    req_a[11:0] = 12'd3; req_b[11:0] = 12'd3;
    req_valid = 2'b01;
    st = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mult_start) begin st = 1'b1; break; end
    end
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (!st || {req_ack, rsp_valid, rsp_prod, rsp_err, busy, mult_x, mult_y, mult_start} !== '0) begin
      failures++;
      $display("FAIL rstbusy_outputs: started=%0d busy=%b x=%h y=%h rv=%b, want all 0",
               st, busy, mult_x, mult_y, rsp_valid);
    end
    mult_prod = 24'd9;
    mult_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      mult_ready = 1'b0;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rstbusy_discard: %0d bad cycles, want 0", bad);
    end
    req_a[23:12] = 12'd5; req_b[23:12] = 12'hFFF;
    req_valid = 2'b10;
    run_mult(3, 1'b0, 1'b1, st2, sc, ack, x, y, rk, rc, rv, pr, er, bn);
    checks++;
    if (!st2 || ack !== 2'b10 || rk != 4 || rv !== 2'b10 || pr !== 24'hFFFFFB || er !== 1'b0) begin
      failures++;
      $display("FAIL rstbusy_next: ack=%b k=%0d rv=%b prod=%h err=%b, want 10 4 10 fffffb 0",
               ack, rk, rv, pr, er);
    end
  endtask

  task automatic test_withdraw();
    bit st;
    int rk, nrsp, extra_start, ack0, hold_bad;
    logic [23:0] pr;
    req_a = {12'd6, 12'd11}; req_b = {12'd7, 12'd13};
    req_valid = 2'b10;
    st = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mult_start) begin st = 1'b1; break; end
    end
    req_valid = 2'b00;
    mult_prod = 24'd42;
    rk = -1; nrsp = 0; extra_start = 0; ack0 = 0; hold_bad = 0; pr = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mult_start) extra_start++;
      if (req_ack[0]) ack0++;
      if (k < 7 && (mult_x !== 12'd6 || mult_y !== 12'd7)) hold_bad++;
      if (|rsp_valid) begin
        nrsp++;
        if (rk < 0) begin rk = k; pr = rsp_prod; end
      end
      if (k == 2) req_valid[0] = 1'b1;
      if (k == 4) req_valid[0] = 1'b0;
      mult_ready = (k == 6) || (k == 10);
    end
    mult_ready = 1'b0;
    checks++;
    if (!st || rk != 7 || nrsp != 1 || pr !== 24'd42) begin
      failures++;
      $display("FAIL withdraw_rsp: started=%0d k=%0d n=%0d prod=%h, want 1 7 1 00002a",
               st, rk, nrsp, pr);
    end
    checks++;
    if (extra_start != 0 || ack0 != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_idle: starts=%0d ack0=%0d busy=%b, want 0 0 0",
               extra_start, ack0, busy);
    end
    checks++;
    if (hold_bad != 0) begin
      failures++; $display("FAIL operand_hold: %0d cycles changed, want 0", hold_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ready_mask();
    test_reset_busy();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
